// File: rtl/vga_quad_painter.sv
// rtl/vga_quad_painter.sv - VGA timing generator painting four screen quadrants from frame-latched colours
module vga_quad_painter #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        ien,
    input  logic [23:0] icolor1,
    input  logic [23:0] icolor2,
    input  logic [23:0] icolor3,
    input  logic [23:0] icolor4,
    output logic        ord,
    output logic        ohsync,
    output logic        ovsync,
    output logic [7:0]  ored,
    output logic [7:0]  ogreen,
    output logic [7:0]  oblue,
    output logic        oblank,
    output logic [9:0]  ohcount,
    output logic [9:0]  ovcount
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ORD    = 10'(H_TOTAL - 2);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] H_MID    = 10'(H_VISIBLE / 2);
    localparam logic [9:0] V_MID    = 10'(V_VISIBLE / 2);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [9:0]  hnext;
    logic [9:0]  vnext;
    logic        hwrap;
    logic        frame_end;
    logic        visible;
    logic [23:0] pix;
    logic [23:0] shadow1;
    logic [23:0] shadow2;
    logic [23:0] shadow3;
    logic [23:0] shadow4;

    always_comb begin
        hwrap     = (hcnt == H_LAST);
        frame_end = hwrap && (vcnt == V_LAST);
        hnext     = hwrap ? 10'd0 : hcnt + 10'd1;
        vnext     = vcnt;
        if (hwrap) begin
            vnext = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end
        visible = (hcnt < H_VIS) && (vcnt < V_VIS);
        pix     = 24'd0;
        if (visible) begin
            if (vcnt < V_MID) begin
                pix = (hcnt < H_MID) ? shadow1 : shadow2;
            end else begin
                pix = (hcnt < H_MID) ? shadow3 : shadow4;
            end
        end
    end

    // Outputs describe the counter value held during the cycle before the edge;
    // ord is registered on entry to (H_TOTAL-2, V_TOTAL-1) so it is high exactly then.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            hcnt    <= 10'd0;
            vcnt    <= 10'd0;
            ord     <= 1'b0;
            ohsync  <= 1'b1;
            ovsync  <= 1'b1;
            ored    <= 8'd0;
            ogreen  <= 8'd0;
            oblue   <= 8'd0;
            oblank  <= 1'b1;
            ohcount <= 10'd0;
            ovcount <= 10'd0;
            shadow1 <= 24'd0;
            shadow2 <= 24'd0;
            shadow3 <= 24'd0;
            shadow4 <= 24'd0;
        end else if (ien) begin
            hcnt    <= hnext;
            vcnt    <= vnext;
            ord     <= (hnext == H_ORD) && (vnext == V_LAST);
            ohsync  <= !((hcnt >= HS_START) && (hcnt < HS_END));
            ovsync  <= !((vcnt >= VS_START) && (vcnt < VS_END));
            ored    <= pix[23:16];
            ogreen  <= pix[15:8];
            oblue   <= pix[7:0];
            oblank  <= !visible;
            ohcount <= hcnt;
            ovcount <= vcnt;
            if (frame_end) begin
                shadow1 <= icolor1;
                shadow2 <= icolor2;
                shadow3 <= icolor3;
                shadow4 <= icolor4;
            end
        end else begin
            ord     <= 1'b0;
            ohsync  <= 1'b1;
            ovsync  <= 1'b1;
            ored    <= 8'd0;
            ogreen  <= 8'd0;
            oblue   <= 8'd0;
            oblank  <= 1'b1;
            ohcount <= 10'd0;
            ovcount <= 10'd0;
        end
    end

endmodule

// File: tb/tb_vga_quad_painter.sv
// tb/tb_vga_quad_painter.sv - directed bench for vga_quad_painter on a reduced 15x10 raster
module tb_vga_quad_painter;

    // 8/2/3/2 horizontal (total 15), 6/1/2/1 vertical (total 10): frame = 150 cycles
    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        ien  = 1'b0;
    logic [23:0] icolor1 = 24'hFF0000;
    logic [23:0] icolor2 = 24'h00FF00;
    logic [23:0] icolor3 = 24'h0000FF;
    logic [23:0] icolor4 = 24'hFFFFFF;
    logic        ord, ohsync, ovsync, oblank;
    logic [7:0]  ored, ogreen, oblue;
    logic [9:0]  ohcount, ovcount;

    int checks   = 0;
    int failures = 0;

    vga_quad_painter #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut (
        .iclk(iclk), .irst(irst), .ien(ien),
        .icolor1(icolor1), .icolor2(icolor2), .icolor3(icolor3), .icolor4(icolor4),
        .ord(ord), .ohsync(ohsync), .ovsync(ovsync),
        .ored(ored), .ogreen(ogreen), .oblue(oblue),
        .oblank(oblank), .ohcount(ohcount), .ovcount(ovcount)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
        logic        blank;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic at_reset();
        return (ord == 1'b0) && ohsync && ovsync && oblank &&
               ({ored, ogreen, oblue} == 24'd0) && (ohcount == 10'd0) && (ovcount == 10'd0);
    endfunction

    task automatic wait_xy(input string name, input logic [9:0] x, input logic [9:0] y);
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge iclk);
            if (ohcount == x && ovcount == y && !oblank) found = 1;
            if (ohcount == x && ovcount == y && (x >= 10'd8 || y >= 10'd6)) found = 1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for (%0d,%0d)", name, x, y);
        end
    endtask

    initial begin
        int hs_lows, vs_lows, ord_highs, black_bad, bad;

        tbl[0]  = '{10'd0,  10'd0, 24'hFF0000, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{10'd4,  10'd0, 24'h00FF00, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{10'd7,  10'd0, 24'h00FF00, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{10'd8,  10'd0, 24'h000000, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{10'd10, 10'd0, 24'h000000, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{10'd12, 10'd0, 24'h000000, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{10'd13, 10'd0, 24'h000000, 1'b1, 1'b1, 1'b1};
        tbl[7]  = '{10'd3,  10'd2, 24'hFF0000, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{10'd0,  10'd3, 24'h0000FF, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{10'd4,  10'd3, 24'hFFFFFF, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{10'd7,  10'd5, 24'hFFFFFF, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{10'd0,  10'd6, 24'h000000, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{10'd0,  10'd7, 24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{10'd14, 10'd8, 24'h000000, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{10'd0,  10'd9, 24'h000000, 1'b1, 1'b1, 1'b1};

        repeat (3) @(negedge iclk);
        check("reset_outputs", 64'(at_reset()), 64'd1);
        irst = 1'b0;
        ien  = 1'b1;

        // Two free-running frames: sample k shows internal count k-1
        hs_lows = 0; vs_lows = 0; ord_highs = 0; black_bad = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge iclk);
            if (!ohsync) hs_lows++;
            if (!ovsync) vs_lows++;
            if (ord) ord_highs++;
            if (k <= 150 && {ored, ogreen, oblue} != 24'd0) black_bad++;
        end
        check("hsync_low_cycles", 64'(hs_lows), 64'd60);
        check("vsync_low_cycles", 64'(vs_lows), 64'd60);
        check("ord_high_cycles", 64'(ord_highs), 64'd2);
        check("first_frame_black", 64'(black_bad), 64'd0);

        for (int i = 0; i < 15; i++) begin
            wait_xy("table_wait", tbl[i].x, tbl[i].y);
            check($sformatf("pixel_%0d_%0d", tbl[i].x, tbl[i].y),
                  64'({ored, ogreen, oblue, oblank, ohsync, ovsync}),
                  64'({tbl[i].rgb, tbl[i].blank, tbl[i].hs, tbl[i].vs}));
        end

        // Colour change mid-frame is deferred to the next frame
        wait_xy("chg_wait", 10'd2, 10'd1);
        icolor1 = 24'h123456;
        wait_xy("chg_old_wait", 10'd3, 10'd2);
        check("chg_old_colour", 64'({ored, ogreen, oblue}), 64'h FF0000);
        bad = 1;
        for (int i = 0; i < 200 && bad; i++) begin
            @(negedge iclk);
            if (ord) bad = 0;
        end
        check("ord_position", 64'({bad[0], ohcount, ovcount}), 64'({1'b0, 10'd12, 10'd9}));
        @(negedge iclk);
        check("ord_one_cycle", 64'(ord), 64'd0);
        wait_xy("chg_new_wait", 10'd0, 10'd0);
        check("chg_new_colour", 64'({ored, ogreen, oblue}), 64'h123456);

        // Scan enable pause
        wait_xy("ien_wait", 10'd5, 10'd1);
        ien = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge iclk);
            if (!at_reset()) bad++;
        end
        check("ien_low_outputs", 64'(bad), 64'd0);
        ien = 1'b1;
        @(negedge iclk);
        check("ien_resume_pos", 64'({ohcount, ovcount}), 64'({10'd6, 10'd1}));
        @(negedge iclk);
        check("ien_resume_next", 64'(ohcount), 64'd7);

        // Asynchronous reset between edges
        wait_xy("rst_wait", 10'd5, 10'd4);
        check("pre_reset_pixel", 64'({ored, ogreen, oblue}), 64'hFFFFFF);
        #2 irst = 1'b1;
        #1 check("async_reset", 64'(at_reset()), 64'd1);
        @(negedge iclk);
        irst = 1'b0;
        @(negedge iclk);
        check("restart_origin", 64'({ohcount, ovcount, oblank, ored, ogreen, oblue}),
              64'({10'd0, 10'd0, 1'b0, 24'd0}));
        @(negedge iclk);
        check("restart_next", 64'({ohcount, ovcount}), 64'({10'd1, 10'd0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
